// File: rtl/mem_reduce_unit.sv
// Walks `count` words of an internal register file from `start_address` (wrapping) and reduces them by sum/max/min/xor.
// Latency count+1 cycles from accepted start to done; start is accepted only in IDLE and is otherwise dropped, never queued.
module mem_reduce_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_address,
   input  logic [ADDR_W:0]   count,
   input  logic [1:0]        mode,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  out,
   output logic              overflow
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [1:0]        M_SUM   = 2'b00;
   localparam logic [1:0]        M_MAX   = 2'b01;
   localparam logic [1:0]        M_MIN   = 2'b10;
   localparam logic [1:0]        M_XOR   = 2'b11;
   localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);
   localparam logic [OUT_W-1:0]  MIN_INIT = OUT_W'({DATA_W{1'b1}});

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   rem_q;
   logic [1:0]        mode_q;
   logic [OUT_W-1:0]  acc_q;
   logic [OUT_W-1:0]  out_q;
   logic              ovf_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [OUT_W-1:0]  rd_ext;
   logic [OUT_W:0]    sum_w;
   logic [OUT_W-1:0]  acc_d;
   logic              carry_d;

   // Combinational read of the pre-edge memory gives read-before-write on address collisions.
   always_comb begin
      rd_ext  = OUT_W'(mem_q[addr_q]);
      sum_w   = {1'b0, acc_q} + {1'b0, rd_ext};
      acc_d   = acc_q;
      carry_d = 1'b0;
      case (mode_q)
         M_SUM: begin
            acc_d   = sum_w[OUT_W-1:0];
            carry_d = sum_w[OUT_W];
         end
         M_MAX: acc_d = (rd_ext > acc_q) ? rd_ext : acc_q;
         M_MIN: acc_d = (rd_ext < acc_q) ? rd_ext : acc_q;
         M_XOR: acc_d = acc_q ^ rd_ext;
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         mode_q  <= M_SUM;
         acc_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q <= start_address;
                  rem_q  <= count;
                  mode_q <= mode;
                  acc_q  <= (mode == M_MIN) ? MIN_INIT : '0;
                  ovf_q  <= 1'b0;
                  if (count == '0) begin
                     out_q   <= '0;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc_q  <= acc_d;
               addr_q <= addr_q + ADR_ONE;
               rem_q  <= rem_q - REM_ONE;
               if (carry_d) ovf_q <= 1'b1;
               if (rem_q == REM_ONE) begin
                  out_q   <= acc_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign out      = out_q;
   assign overflow = ovf_q;

endmodule
